unstripe_lane_ctrl: RTL and testbench

Controller for the two-lane byte unstripping path. It buffers bytes arriving on stripe lanes 0 and 1 in per-lane FIFOs and releases them to the demux side in strict lane-0/lane-1 alternation. It absorbs inter-lane skew up to the FIFO depth and flags overflow and excessive skew. It sits between the lane receivers and the data demux, in the clk_2f domain.

---
 rtl/unstripe_lane_ctrl.sv | 169 ++++++++++++++++
 tb/tb_unstripe_lane_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unstripe_lane_ctrl.sv
// rtl/unstripe_lane_ctrl.sv - two-lane byte unstripper with per-lane FIFOs, skew and overflow detection
module unstripe_lane_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int SKEW_MAX   = 3
) (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] data_stripe_0,
    input  logic       valid_stripe_0,
    input  logic [7:0] data_stripe_1,
    input  logic       valid_stripe_1,
    input  logic       clear_err,
    output logic [7:0] data_demux,
    output logic       valid_demux,
    output logic       lane_sel,
    output logic       err_overflow,
    output logic       err_skew,
    output logic [1:0] state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SKEW_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_ERROR = 2'b10
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     mem0_q [FIFO_DEPTH];
    logic [7:0]     mem1_q [FIFO_DEPTH];
    logic [AW-1:0]  wptr0_q, wptr0_d, rptr0_q, rptr0_d;
    logic [AW-1:0]  wptr1_q, wptr1_d, rptr1_q, rptr1_d;
    logic [CW-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [SW-1:0]  skew_q, skew_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           lane_sel_q, lane_sel_d;
    logic           err_ovf_q, err_ovf_d;
    logic           err_skew_q, err_skew_d;

    logic pop0, pop1, elig0, elig1, push0, push1, drop0, drop1;
    logic skew_evt, flush;
    logic sel_has, other_has;

    assign sel_has   = lane_sel_q ? (cnt1_q != '0) : (cnt0_q != '0);
    assign other_has = lane_sel_q ? (cnt0_q != '0) : (cnt1_q != '0);

    always_comb begin
        state_d    = state_q;
        lane_sel_d = lane_sel_q;
        skew_d     = skew_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        pop0       = 1'b0;
        pop1       = 1'b0;
        elig0      = 1'b1;
        elig1      = 1'b1;
        skew_evt   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Lane 1 may only start a stream once lane 0 has data, keeping lanes aligned.
                elig1 = (cnt0_q != '0) || valid_stripe_0;
                if (cnt0_q != '0) begin
                    pop0       = 1'b1;
                    valid_d    = 1'b1;
                    data_d     = mem0_q[rptr0_q];
                    lane_sel_d = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (sel_has) begin
                    pop0       = ~lane_sel_q;
                    pop1       = lane_sel_q;
                    valid_d    = 1'b1;
                    data_d     = lane_sel_q ? mem1_q[rptr1_q] : mem0_q[rptr0_q];
                    lane_sel_d = ~lane_sel_q;
                    skew_d     = '0;
                end else if (other_has) begin
                    if (skew_q == SW'(SKEW_MAX - 1)) begin
                        skew_evt = 1'b1;
                        skew_d   = '0;
                        state_d  = S_ERROR;
                    end else begin
                        skew_d = skew_q + SW'(1);
                    end
                end else begin
                    skew_d = '0;
                    if (!lane_sel_q && !valid_stripe_0 && !valid_stripe_1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERROR: begin
                elig0 = 1'b0;
                elig1 = 1'b0;
                if (clear_err) begin
                    state_d    = S_IDLE;
                    lane_sel_d = 1'b0;
                    skew_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        flush      = (state_q == S_ERROR);
        push0      = valid_stripe_0 && elig0 && ((cnt0_q != CW'(FIFO_DEPTH)) || pop0);
        push1      = valid_stripe_1 && elig1 && ((cnt1_q != CW'(FIFO_DEPTH)) || pop1);
        drop0      = valid_stripe_0 && elig0 && !push0;
        drop1      = valid_stripe_1 && elig1 && !push1;
        cnt0_d     = flush ? '0 : cnt0_q + CW'(push0) - CW'(pop0);
        cnt1_d     = flush ? '0 : cnt1_q + CW'(push1) - CW'(pop1);
        wptr0_d    = flush ? '0 : wptr0_q + AW'(push0);
        wptr1_d    = flush ? '0 : wptr1_q + AW'(push1);
        rptr0_d    = flush ? '0 : rptr0_q + AW'(pop0);
        rptr1_d    = flush ? '0 : rptr1_q + AW'(pop1);
        // A same-cycle error event beats clear_err so the flag stays set.
        err_ovf_d  = drop0 || drop1 || (err_ovf_q && !clear_err);
        err_skew_d = skew_evt || (err_skew_q && !clear_err);
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wptr0_q    <= '0;
            rptr0_q    <= '0;
            wptr1_q    <= '0;
            rptr1_q    <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            skew_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            lane_sel_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_skew_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr0_q    <= wptr0_d;
            rptr0_q    <= rptr0_d;
            wptr1_q    <= wptr1_d;
            rptr1_q    <= rptr1_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            skew_q     <= skew_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            lane_sel_q <= lane_sel_d;
            err_ovf_q  <= err_ovf_d;
            err_skew_q <= err_skew_d;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (!reset && push0) mem0_q[wptr0_q] <= data_stripe_0;
        if (!reset && push1) mem1_q[wptr1_q] <= data_stripe_1;
    end

    assign data_demux   = data_q;
    assign valid_demux  = valid_q;
    assign lane_sel     = lane_sel_q;
    assign err_overflow = err_ovf_q;
    assign err_skew     = err_skew_q;
    assign state        = state_q;
endmodule

// File: tb/tb_unstripe_lane_ctrl.sv
// tb/tb_unstripe_lane_ctrl.sv - scoreboard bench for unstripe_lane_ctrl
module tb_unstripe_lane_ctrl;
    logic       clk;
    logic       reset;
    logic [7:0] data_stripe_0, data_stripe_1;
    logic       valid_stripe_0, valid_stripe_1;
    logic       clear_err;

    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid, a_lane, b_lane, a_ovf, b_ovf, a_skew, b_skew;
    logic [1:0] a_state, b_state;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic       mon_en = 1'b0;
    logic       use_b  = 1'b0;
    logic       mv;
    logic [7:0] md, me;

    // dut_b has a generous skew limit so a lane FIFO can fill before a skew error.
    unstripe_lane_ctrl #(.FIFO_DEPTH(4), .SKEW_MAX(3)) dut_a (
        .clk_2f(clk), .reset(reset),
        .data_stripe_0(data_stripe_0), .valid_stripe_0(valid_stripe_0),
        .data_stripe_1(data_stripe_1), .valid_stripe_1(valid_stripe_1),
        .clear_err(clear_err),
        .data_demux(a_data), .valid_demux(a_valid), .lane_sel(a_lane),
        .err_overflow(a_ovf), .err_skew(a_skew), .state(a_state)
    );

    unstripe_lane_ctrl #(.FIFO_DEPTH(4), .SKEW_MAX(16)) dut_b (
        .clk_2f(clk), .reset(reset),
        .data_stripe_0(data_stripe_0), .valid_stripe_0(valid_stripe_0),
        .data_stripe_1(data_stripe_1), .valid_stripe_1(valid_stripe_1),
        .clear_err(clear_err),
        .data_demux(b_data), .valid_demux(b_valid), .lane_sel(b_lane),
        .err_overflow(b_ovf), .err_skew(b_skew), .state(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            mv = use_b ? b_valid : a_valid;
            md = use_b ? b_data : a_data;
            if (mv) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got %02h, required no output", md);
                end else begin
                    me = exp_q.pop_front();
                    if (md !== me) begin
                        n_fail++;
                        $display("FAIL demux_data: got %02h, required %02h", md, me);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic v0, input logic [7:0] dd0, input logic v1,
                         input logic [7:0] dd1, input logic clr);
        valid_stripe_0 = v0;
        data_stripe_0  = dd0;
        valid_stripe_1 = v1;
        data_stripe_1  = dd1;
        clear_err      = clr;
        step();
        valid_stripe_0 = 1'b0;
        valid_stripe_1 = 1'b0;
        clear_err      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++;
        if ({a_data, a_valid, a_lane, a_ovf, a_skew, a_state} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_initial: got %04h, required 0000",
                     {a_data, a_valid, a_lane, a_ovf, a_skew, a_state});
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b1, 8'(8'h40 + i), 1'b0);
        valid_stripe_0 = 1'b1;
        valid_stripe_1 = 1'b1;
        data_stripe_0  = 8'h3F;
        data_stripe_1  = 8'h4F;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        valid_stripe_0 = 1'b0;
        valid_stripe_1 = 1'b0;
        n_cmp++;
        if ({a_data, a_valid, a_lane, a_ovf, a_skew, a_state} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_midstream_a: got %04h, required 0000",
                     {a_data, a_valid, a_lane, a_ovf, a_skew, a_state});
        end
        n_cmp++;
        if ({b_data, b_valid, b_lane, b_ovf, b_skew, b_state} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_midstream_b: got %04h, required 0000",
                     {b_data, b_valid, b_lane, b_ovf, b_skew, b_state});
        end
        exp_q.delete();
        mon_en = 1'b1;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5B);
        cycle(1'b1, 8'h5A, 1'b1, 8'h5B, 1'b0);
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0 || a_state !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_restart: got pending=%0d state=%b, required pending=0 state=00",
                     exp_q.size(), a_state);
        end
    endtask

    task automatic test_ordered();
        use_b = 1'b0;
        do_reset();
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        cycle(1'b1, 8'hA0, 1'b1, 8'hA1, 1'b0);
        idle(1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        cycle(1'b1, 8'hA2, 1'b1, 8'hA3, 1'b0);
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ordered_drain: got pending=%0d, required 0", exp_q.size());
        end
        n_cmp++;
        if (a_state !== 2'b00 || a_lane !== 1'b0) begin
            n_fail++;
            $display("FAIL ordered_idle: got state=%b lane=%b, required state=00 lane=0", a_state, a_lane);
        end
    endtask

    task automatic test_idle_align();
        use_b = 1'b0;
        do_reset();
        cycle(1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
        idle(1);
        exp_q.push_back(8'h10);
        cycle(1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
        step();
        n_cmp++;
        if (a_valid !== 1'b1 || a_data !== 8'h10) begin
            n_fail++;
            $display("FAIL align_latency: got valid=%b data=%02h, required valid=1 data=10", a_valid, a_data);
        end
        n_cmp++;
        if (a_state !== 2'b01 || a_lane !== 1'b1 || a_ovf !== 1'b0 || a_skew !== 1'b0) begin
            n_fail++;
            $display("FAIL align_state: got state=%b lane=%b ovf=%b skew=%b, required 01 1 0 0",
                     a_state, a_lane, a_ovf, a_skew);
        end
        idle(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL align_drain: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1;
        use_b = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            exp_q.push_back(b0);
            exp_q.push_back(b1);
            cycle(1'b1, b0, 1'b1, b1, 1'b0);
            if (i < 5) idle(1);
        end
        idle(2);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_throughput: got pending=%0d, required 0", exp_q.size());
        end
        idle(3);
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        use_b = 1'b1;
        do_reset();
        exp_q.push_back(8'h01);
        cycle(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
        idle(2);
        for (int i = 0; i < 6; i++) begin
            d = 8'(8'h02 + i);
            if (i == 0) exp_q.push_back(d);
            cycle(1'b0, 8'h00, 1'b1, d, 1'b0);
            if (i == 4) begin
                n_cmp++;
                if (b_ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_early: got %b, required 0", b_ovf);
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (b_ovf !== 1'b1 || b_state !== 2'b01) begin
                    n_fail++;
                    $display("FAIL ovf_drop: got ovf=%b state=%b, required ovf=1 state=01", b_ovf, b_state);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(8'h11 + i));
            exp_q.push_back(8'(8'h03 + i));
            cycle(1'b1, 8'(8'h11 + i), 1'b0, 8'h00, 1'b0);
        end
        idle(10);
        n_cmp++;
        if (exp_q.size() != 0 || b_state !== 2'b00 || b_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drain: got pending=%0d state=%b ovf=%b, required 0 00 1",
                     exp_q.size(), b_state, b_ovf);
        end
    endtask

    task automatic test_simultaneous();
        use_b = 1'b1;
        do_reset();
        exp_q.push_back(8'h01);
        cycle(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
        idle(2);
        exp_q.push_back(8'h02);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 8'(8'h02 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 8'h07, 1'b1);
        n_cmp++;
        if (b_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_event_wins: got %b, required 1", b_ovf);
        end
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (b_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_clear: got %b, required 0", b_ovf);
        end
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL simul_drain: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_skew();
        use_b = 1'b0;
        do_reset();
        exp_q.push_back(8'h01);
        cycle(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (a_state !== 2'b01 || a_skew !== 1'b0) begin
                n_fail++;
                $display("FAIL skew_stall%0d: got state=%b skew=%b, required 01 0", i, a_state, a_skew);
            end
        end
        step();
        n_cmp++;
        if (a_state !== 2'b10 || a_skew !== 1'b1) begin
            n_fail++;
            $display("FAIL skew_error: got state=%b skew=%b, required 10 1", a_state, a_skew);
        end
        idle(2);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (a_state !== 2'b00 || a_skew !== 1'b0 || a_lane !== 1'b0) begin
            n_fail++;
            $display("FAIL skew_clear: got state=%b skew=%b lane=%b, required 00 0 0", a_state, a_skew, a_lane);
        end
        exp_q.push_back(8'h77);
        cycle(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL skew_restart: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    initial begin
        reset          = 1'b1;
        valid_stripe_0 = 1'b0;
        valid_stripe_1 = 1'b0;
        data_stripe_0  = 8'h00;
        data_stripe_1  = 8'h00;
        clear_err      = 1'b0;
        test_reset();
        test_ordered();
        test_idle_align();
        test_back_to_back();
        test_overflow();
        test_simultaneous();
        test_skew();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
